ex_mem: RTL and testbench

Pipeline register between the execute and memory stages of the CPU core, using a valid/ready handshake in both directions. It accepts one executed instruction per cycle from EX, presents it to MEM, and absorbs downstream stalls with an optional skid entry so `ex_ready` is a registered signal. A synchronous `flush` discards in-flight instructions on exceptions and branch redirects.

---
 rtl/ex_mem.sv | 149 ++++++++++++++
 tb/tb_ex_mem.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register with valid/ready handshakes on both sides.
//
// Optional feature macro: EX_MEM_SKID_EN
//   defined   : main + skid entry (EMPTY/ONE/TWO); ex_ready is a flop output,
//               so there is no combinational path from mem_ready to ex_ready.
//   undefined : main entry only (EMPTY/ONE); ex_ready = !mem_valid || mem_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous discard of every held entry
//   ex_valid/ex_ready   upstream handshake
//   ex_op .. ex_reg_waddr    instruction fields from EX
//   mem_valid/mem_ready downstream handshake
//   mem_op .. mem_reg_waddr  instruction fields presented to MEM (main entry)
//
// Field widths: Oper_t = 8 bits (OP_NOP = 8'h00), InstAddr_t/Word_t = 32,
// Bit_t = 1, RegAddr_t = 5.
module ex_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [7:0]  ex_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_reg_we,
  input  logic [4:0]  ex_reg_waddr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [7:0]  mem_op,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic [31:0] mem_store_data,
  output logic        mem_reg_we,
  output logic [4:0]  mem_reg_waddr
);

  localparam logic [7:0] OP_NOP = 8'h00;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] store_data;
    logic        reg_we;
    logic [4:0]  reg_waddr;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, in_e;
  logic   accept, consume;

  assign in_e    = '{op: ex_op, pc: ex_pc, result: ex_result,
                     store_data: ex_store_data, reg_we: ex_reg_we,
                     reg_waddr: ex_reg_waddr};
  assign mem_valid = (state_q != S_EMPTY);
  assign accept    = ex_valid && ex_ready;
  assign consume   = mem_valid && mem_ready;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q, skid_d;
  logic   ex_ready_q;

  assign ex_ready = ex_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: if (accept) begin
        state_d = S_ONE;
        main_d  = in_e;
      end
      S_ONE: begin
        if (accept && consume) begin
          main_d = in_e;
        end else if (accept) begin
          // MEM stalled: park the newcomer behind the held instruction
          state_d = S_TWO;
          skid_d  = in_e;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: if (consume) begin
        state_d = S_ONE;
        main_d  = skid_q;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      ex_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      // mirrors next state so ex_ready comes straight from a flop
      ex_ready_q <= (state_d != S_TWO);
    end
  end
`else
  assign ex_ready = !mem_valid || mem_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      S_EMPTY: if (accept) begin
        state_d = S_ONE;
        main_d  = in_e;
      end
      S_ONE: begin
        // in ONE an accept implies a consume, so it is a straight replace
        if (accept)       main_d  = in_e;
        else if (consume) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '{op: OP_NOP, default: '0};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // op and reg_we are gated so an idle slot reads as a harmless bubble
  assign mem_op         = mem_valid ? main_q.op : OP_NOP;
  assign mem_reg_we     = mem_valid && main_q.reg_we;
  assign mem_pc         = main_q.pc;
  assign mem_result     = main_q.result;
  assign mem_store_data = main_q.store_data;
  assign mem_reg_waddr  = main_q.reg_waddr;

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;
  logic        clk = 1'b0;
  logic        rst_n, flush, ex_valid, ex_ready, ex_reg_we, mem_valid, mem_ready, mem_reg_we;
  logic [7:0]  ex_op, mem_op;
  logic [31:0] ex_pc, ex_result, ex_store_data, mem_pc, mem_result, mem_store_data;
  logic [4:0]  ex_reg_waddr, mem_reg_waddr;
  int          nchk = 0, nerr = 0;

  ex_mem dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_pc(ex_pc),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_reg_we(ex_reg_we),
    .ex_reg_waddr(ex_reg_waddr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_op(mem_op), .mem_pc(mem_pc), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_reg_we(mem_reg_we),
    .mem_reg_waddr(mem_reg_waddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // fields derived from pc so expected values are easy to recompute
  function automatic logic [7:0] op_of(input logic [31:0] pc);
    logic [7:0] lo;
    lo = pc[7:0];
    return lo ^ 8'h5A;
  endfunction

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] res);
    ex_valid      = v;
    ex_pc         = pc;
    ex_result     = res;
    ex_op         = op_of(pc);
    ex_store_data = ~res;
    ex_reg_we     = 1'b1;
    ex_reg_waddr  = pc[6:2];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc, input logic [31:0] res);
    chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
    chk({tag, "_pc"},    mem_pc, pc);
    chk({tag, "_op"},    {24'd0, mem_op}, {24'd0, op_of(pc)});
    chk({tag, "_res"},   mem_result, res);
    chk({tag, "_sd"},    mem_store_data, ~res);
    chk({tag, "_we"},    {31'd0, mem_reg_we}, 32'd1);
    chk({tag, "_wa"},    {27'd0, mem_reg_waddr}, {27'd0, pc[6:2]});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd0);
    chk({tag, "_op"},    {24'd0, mem_op}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_reg_we}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #2;
    chk_empty("rst");
    chk("rst_pc", mem_pc, 32'h0);
    chk("rst_res", mem_result, 32'h0);
    chk("rst_wa", {27'd0, mem_reg_waddr}, 32'h0);
    chk("rst_rdy", {31'd0, ex_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // streaming: one per cycle, visible the cycle after acceptance
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      chk("str_rdy", {31'd0, ex_ready}, 32'd1);
      step();
      chk_entry("str", 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
    end
    offer(1'b0, 32'h0, 32'h0);
    step();
    chk_empty("str_drain");

    // stall with two offers
    mem_ready = 1'b0;
    offer(1'b1, 32'h200, 32'h2000);
    step();
    chk_entry("stl_a", 32'h200, 32'h2000);
`ifdef EX_MEM_SKID_EN
    chk("stl_rdy1", {31'd0, ex_ready}, 32'd1);
    offer(1'b1, 32'h204, 32'h2004);
    step();
    offer(1'b0, 32'h0, 32'h0);
    chk("stl_rdy2", {31'd0, ex_ready}, 32'd0);
    chk("stl_hold", mem_pc, 32'h200);
    step();
    chk("stl_hold2", mem_pc, 32'h200);
`else
    // ex_ready drops in the same cycle that MEM is stalled
    chk("stl_rdy_comb", {31'd0, ex_ready}, 32'd0);
    offer(1'b1, 32'h204, 32'h2004);
    step();
    chk("stl_hold", mem_pc, 32'h200);
    chk("stl_rdy_hold", {31'd0, ex_ready}, 32'd0);
`endif
    mem_ready = 1'b1;
    #1;
    chk("stl_rel0", mem_pc, 32'h200);
    step();
    offer(1'b0, 32'h0, 32'h0);
    chk_entry("stl_b", 32'h204, 32'h2004);
    chk("stl_rdy3", {31'd0, ex_ready}, 32'd1);
    step();
    chk_empty("stl_done");

    // flush with a fresh offer while full
    mem_ready = 1'b0;
    offer(1'b1, 32'h240, 32'h2400);
    step();
`ifdef EX_MEM_SKID_EN
    offer(1'b1, 32'h244, 32'h2440);
    step();
    chk("fl_two_rdy", {31'd0, ex_ready}, 32'd0);
`endif
    flush = 1'b1;
    offer(1'b1, 32'h300, 32'h3000);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk_empty("fl_full");
    chk("fl_rdy", {31'd0, ex_ready}, 32'd1);
    mem_ready = 1'b1;
    step();
    chk_empty("fl_after");

    // flush while ONE and ready: the offered instruction must be dropped
    offer(1'b1, 32'h280, 32'h2800);
    step();
    flush = 1'b1;
    offer(1'b1, 32'h304, 32'h3040);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk_empty("fl_one");

    // simultaneous accept and consume in ONE
    offer(1'b1, 32'h400, 32'h1111);
    step();
    chk_entry("ac_a", 32'h400, 32'h1111);
    offer(1'b1, 32'h404, 32'hDEADBEEF);
    step();
    offer(1'b0, 32'h0, 32'h0);
    chk_entry("ac_b", 32'h404, 32'hDEADBEEF);
    chk("ac_rdy", {31'd0, ex_ready}, 32'd1);
    step();
    chk_empty("ac_done");

    // reset mid-stream with entries held
    mem_ready = 1'b0;
    offer(1'b1, 32'h440, 32'h4400);
    step();
`ifdef EX_MEM_SKID_EN
    offer(1'b1, 32'h444, 32'h4440);
    step();
`endif
    offer(1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_empty("mrst");
    chk("mrst_pc", mem_pc, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("mrst_rdy", {31'd0, ex_ready}, 32'd1);
    step();
    chk_empty("mrst_idle");
    mem_ready = 1'b1;
    offer(1'b1, 32'h500, 32'h5000);
    step();
    offer(1'b0, 32'h0, 32'h0);
    chk_entry("mrst_new", 32'h500, 32'h5000);
    step();
    chk_empty("mrst_noskid");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
